// File: rtl/func_request_issuer_pkg.sv
// Shared constants and types for the functionality-arbitration initiator.
// Function bit indices, priority encodings and the request vector type.
package func_request_issuer_pkg;

    localparam int FUNC_W = 3;

    localparam int FUNC_0 = 0;
    localparam int FUNC_1 = 1;
    localparam int FUNC_2 = 2;

    localparam logic PRIO_PANEL1 = 1'b0;
    localparam logic PRIO_PANEL2 = 1'b1;

    typedef logic [FUNC_W-1:0] func_vec_t;

    // A panel is denied when it holds a request the comparator did not grant.
    function automatic logic any_denied(input func_vec_t req, input func_vec_t grant);
        return |(req & ~grant);
    endfunction

endpackage

// File: rtl/func_debounce.sv
// One button bit: 2-FF synchronizer, stability counter and debounced level,
// with a one-cycle pulse on each accepted rising transition.
module func_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync_q1;
    logic             sync_q2;
    logic             deb_level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1   <= 1'b0;
            sync_q2   <= 1'b0;
            deb_level <= 1'b0;
            cnt       <= '0;
            rise      <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            rise    <= 1'b0;
            if (sync_q2 == deb_level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // Level differs here, so the new level alone tells us the edge direction.
                deb_level <= sync_q2;
                rise      <= sync_q2;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/func_request_issuer.sv
// Initiator side of the functionality arbitration: debounced press-to-toggle
// requests per panel, denial flags, and optional priority rotation (FAIR_ROTATE_EN).
module func_request_issuer
    import func_request_issuer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STARVE_CYCLES   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FUNC_W-1:0] btn1,
    input  logic [FUNC_W-1:0] btn2,
    input  logic              clr1,
    input  logic              clr2,
    input  logic [FUNC_W-1:0] grant1,
    input  logic [FUNC_W-1:0] grant2,
    output logic [FUNC_W-1:0] f1,
    output logic [FUNC_W-1:0] f2,
    output logic              p_signal,
    output logic              denied1,
    output logic              denied2
);

    logic [2*FUNC_W-1:0] btn_all;
    logic [2*FUNC_W-1:0] rise_all;
    func_vec_t           rise1;
    func_vec_t           rise2;

    assign btn_all = {btn2, btn1};
    assign rise1   = rise_all[FUNC_W-1:0];
    assign rise2   = rise_all[2*FUNC_W-1:FUNC_W];

    for (genvar i = 0; i < 2*FUNC_W; i++) begin : g_deb
        func_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .btn  (btn_all[i]),
            .rise (rise_all[i])
        );
    end

    // Clear wins over a toggle landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f1      <= '0;
            f2      <= '0;
            denied1 <= 1'b0;
            denied2 <= 1'b0;
        end else begin
            f1      <= clr1 ? '0 : (f1 ^ rise1);
            f2      <= clr2 ? '0 : (f2 ^ rise2);
            denied1 <= any_denied(f1, grant1);
            denied2 <= any_denied(f2, grant2);
        end
    end

`ifdef FAIR_ROTATE_EN
    localparam int STARVE_W = $clog2(STARVE_CYCLES + 1);
    localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_CYCLES - 1);

    logic                conflict;
    logic [STARVE_W-1:0] starve_cnt;

    assign conflict = |(f1 & f2);

    // The current conflict cycle is the STARVE_CYCLES-th when the count shows one less.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            p_signal   <= PRIO_PANEL1;
        end else if (!conflict) begin
            starve_cnt <= '0;
        end else if (starve_cnt == STARVE_LAST) begin
            starve_cnt <= '0;
            p_signal   <= (p_signal == PRIO_PANEL1) ? PRIO_PANEL2 : PRIO_PANEL1;
        end else begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign p_signal = PRIO_PANEL1;
`endif

endmodule

// File: tb/tb_func_request_issuer.sv
// Directed bench for func_request_issuer with a combinational comparator model;
// expectations follow the FAIR_ROTATE_EN setting of the build.
module tb_func_request_issuer;
    import func_request_issuer_pkg::*;

`ifdef FAIR_ROTATE_EN
    localparam logic ROT = 1'b1;
`else
    localparam logic ROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  btn1 = 3'b000;
    logic [2:0]  btn2 = 3'b000;
    logic        clr1 = 1'b0;
    logic        clr2 = 1'b0;
    logic [2:0]  grant1;
    logic [2:0]  grant2;
    logic [2:0]  f1;
    logic [2:0]  f2;
    logic        p_signal;
    logic        denied1;
    logic        denied2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Comparator model: the priority panel keeps shared functions.
    assign grant1 = (p_signal == 1'b0) ? f1 : (f1 & ~f2);
    assign grant2 = (p_signal == 1'b0) ? (f2 & ~f1) : f2;

    func_request_issuer #(
        .DEBOUNCE_CYCLES(4),
        .STARVE_CYCLES  (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn1    (btn1),
        .btn2    (btn2),
        .clr1    (clr1),
        .clr2    (clr2),
        .grant1  (grant1),
        .grant2  (grant2),
        .f1      (f1),
        .f2      (f2),
        .p_signal(p_signal),
        .denied1 (denied1),
        .denied2 (denied2)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        // Reset held with buttons pressed
        btn1 = 3'b111;
        tick(3);
        chk("rst_f1", {5'b0, f1}, 8'h0);
        chk("rst_f2", {5'b0, f2}, 8'h0);
        chk("rst_p", {7'b0, p_signal}, 8'h0);
        chk("rst_d1", {7'b0, denied1}, 8'h0);
        chk("rst_d2", {7'b0, denied2}, 8'h0);
        rst_n = 1'b1;
        tick(7);
        chk("rst_lat_early", {5'b0, f1}, 8'h0);
        tick(1);
        chk("rst_lat", {5'b0, f1}, 8'h7);
        btn1 = 3'b000;
        tick(8);
        chk("fall_ignored", {5'b0, f1}, 8'h7);
        clr1 = 1'b1;
        tick(1);
        clr1 = 1'b0;
        chk("clr1", {5'b0, f1}, 8'h0);

        // Bounce on btn2[1]
        for (int i = 0; i < 4; i++) begin
            btn2 = (i % 2 == 0) ? 3'b010 : 3'b000;
            tick(1);
            chk("bounce", {5'b0, f2}, 8'h0);
        end
        btn2 = 3'b010;
        tick(7);
        chk("bounce_early", {5'b0, f2}, 8'h0);
        tick(1);
        chk("bounce_settle", {5'b0, f2}, 8'h2);
        btn2 = 3'b000;

        // Toggle and clear priority
        btn1 = 3'b001;
        tick(8);
        chk("toggle_on", {5'b0, f1}, 8'h1);
        btn1 = 3'b000;
        tick(8);
        btn1 = 3'b001;
        tick(8);
        chk("toggle_off", {5'b0, f1}, 8'h0);
        btn1 = 3'b000;
        tick(8);
        btn1 = 3'b001;
        tick(7);
        clr1 = 1'b1;
        tick(1);
        clr1 = 1'b0;
        chk("clr_over_toggle", {5'b0, f1}, 8'h0);
        btn1 = 3'b000;
        tick(8);
        chk("clr_release", {5'b0, f1}, 8'h0);
        clr2 = 1'b1;
        tick(1);
        clr2 = 1'b0;
        chk("clr2", {5'b0, f2}, 8'h0);

        // Shared-function conflict on bit 2
        btn1 = 3'b100;
        btn2 = 3'b100;
        tick(8);
        chk("conf_f1", {5'b0, f1}, 8'h4);
        chk("conf_f2", {5'b0, f2}, 8'h4);
        chk("grant1_init", {5'b0, grant1}, 8'h4);
        btn1 = 3'b000;
        btn2 = 3'b000;
        tick(1);
        chk("denied2_init", {7'b0, denied2}, 8'h1);
        chk("denied1_init", {7'b0, denied1}, 8'h0);
        tick(6);
        chk("p_before_rot", {7'b0, p_signal}, 8'h0);
        tick(1);
        chk("p_rot", {7'b0, p_signal}, {7'b0, ROT});
`ifndef FAIR_ROTATE_EN
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (i % 10 == 9) begin
                chk("rot_off_p", {7'b0, p_signal}, 8'h0);
                chk("rot_off_d2", {7'b0, denied2}, 8'h1);
            end
        end
`endif
        tick(1);
        chk("denied1_swap", {7'b0, denied1}, {7'b0, ROT});
        chk("denied2_swap", {7'b0, denied2}, {7'b0, ~ROT});
        chk("grant2_swap", {5'b0, grant2}, ROT ? 8'h4 : 8'h0);
        clr2 = 1'b1;
        tick(1);
        clr2 = 1'b0;
        chk("drop_f2", {5'b0, f2}, 8'h0);
        tick(3);
        chk("p_hold", {7'b0, p_signal}, {7'b0, ROT});
        btn2 = 3'b100;
        tick(8);
        chk("repress_f2", {5'b0, f2}, 8'h4);
        btn2 = 3'b000;
        tick(7);
        chk("p_no_early", {7'b0, p_signal}, {7'b0, ROT});
        tick(1);
        chk("p_rot_back", {7'b0, p_signal}, 8'h0);

        // Async reset mid-debounce and mid-starvation
        tick(2);
        btn1 = 3'b010;
        btn2 = 3'b010;
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_f1", {5'b0, f1}, 8'h0);
        chk("arst_f2", {5'b0, f2}, 8'h0);
        chk("arst_p", {7'b0, p_signal}, 8'h0);
        chk("arst_d1", {7'b0, denied1}, 8'h0);
        chk("arst_d2", {7'b0, denied2}, 8'h0);
        tick(2);
        rst_n = 1'b1;
        tick(7);
        chk("no_stale_f1", {5'b0, f1}, 8'h0);
        chk("no_stale_f2", {5'b0, f2}, 8'h0);
        tick(1);
        chk("post_rst_f1", {5'b0, f1}, 8'h2);
        chk("post_rst_f2", {5'b0, f2}, 8'h2);
        tick(7);
        chk("no_early_rot", {7'b0, p_signal}, 8'h0);
        tick(1);
        chk("rot_after_rst", {7'b0, p_signal}, {7'b0, ROT});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
